// File: rtl/stg_wb_q_if.sv
// Bundle between the MEM stage, the writeback retire queue and the register files.
// master: the side that offers records / drains the queue (MEM + RF control).
// slave : the retire queue itself.
interface stg_wb_q_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 48,
  parameter int GP_AW  = 4,
  parameter int SR_AW  = 2,
  parameter int AR_AW  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) ();
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  // MEM -> queue record handshake
  logic              iw_valid;
  logic              ow_ready;
  logic [ADDR_W-1:0] iw_pc;
  logic [DATA_W-1:0] iw_instr;
  logic              iw_gp_we;
  logic [GP_AW-1:0]  iw_gp_addr;
  logic [DATA_W-1:0] iw_result;
  logic              iw_sr_we;
  logic [SR_AW-1:0]  iw_sr_addr;
  logic [ADDR_W-1:0] iw_sr_result;
  logic              iw_ar_we;
  logic [AR_AW-1:0]  iw_ar_addr;
  logic [ADDR_W-1:0] iw_ar_result;

  // Register-file write ports
  logic              iw_drain_en;
  logic              ow_gp_write_enable;
  logic [GP_AW-1:0]  ow_gp_write_addr;
  logic [DATA_W-1:0] ow_gp_write_data;
  logic              ow_sr_write_enable;
  logic [SR_AW-1:0]  ow_sr_write_addr;
  logic [ADDR_W-1:0] ow_sr_write_data;
  logic              ow_ar_write_enable;
  logic [AR_AW-1:0]  ow_ar_write_addr;
  logic [ADDR_W-1:0] ow_ar_write_data;

  // Retire status
  logic                ow_retire;
  logic [ADDR_W-1:0]   ow_pc;
  logic [DATA_W-1:0]   ow_instr;
  logic [CNT_BITS-1:0] ow_count;
  logic [CNT_W-1:0]    ow_retire_count;

  // GP forwarding lookup
  logic [GP_AW-1:0]  iw_fwd_gp_addr;
  logic              ow_fwd_gp_hit;
  logic [DATA_W-1:0] ow_fwd_gp_data;

  modport master (
    output iw_valid, iw_pc, iw_instr,
    output iw_gp_we, iw_gp_addr, iw_result,
    output iw_sr_we, iw_sr_addr, iw_sr_result,
    output iw_ar_we, iw_ar_addr, iw_ar_result,
    output iw_drain_en, iw_fwd_gp_addr,
    input  ow_ready,
    input  ow_gp_write_enable, ow_gp_write_addr, ow_gp_write_data,
    input  ow_sr_write_enable, ow_sr_write_addr, ow_sr_write_data,
    input  ow_ar_write_enable, ow_ar_write_addr, ow_ar_write_data,
    input  ow_retire, ow_pc, ow_instr, ow_count, ow_retire_count,
    input  ow_fwd_gp_hit, ow_fwd_gp_data
  );

  modport slave (
    input  iw_valid, iw_pc, iw_instr,
    input  iw_gp_we, iw_gp_addr, iw_result,
    input  iw_sr_we, iw_sr_addr, iw_sr_result,
    input  iw_ar_we, iw_ar_addr, iw_ar_result,
    input  iw_drain_en, iw_fwd_gp_addr,
    output ow_ready,
    output ow_gp_write_enable, ow_gp_write_addr, ow_gp_write_data,
    output ow_sr_write_enable, ow_sr_write_addr, ow_sr_write_data,
    output ow_ar_write_enable, ow_ar_write_addr, ow_ar_write_data,
    output ow_retire, ow_pc, ow_instr, ow_count, ow_retire_count,
    output ow_fwd_gp_hit, ow_fwd_gp_data
  );
endinterface

// File: rtl/stg_wb_q.sv
// Writeback retire queue: DEPTH-entry in-order FIFO of MEM records that retires
// at most one record per cycle into the GP/SR/AR register files, with a
// youngest-first GP forwarding lookup over the pending entries.
// The interface instance must be built with the same parameter values.
module stg_wb_q #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 48,
  parameter int GP_AW  = 4,
  parameter int SR_AW  = 2,
  parameter int AR_AW  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input logic         iw_clk,
  input logic         iw_rst_n,
  stg_wb_q_if.slave   bus
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  // Record storage; never reset because it is only observable while occupied.
  logic [ADDR_W-1:0] pc_mem       [DEPTH];
  logic [DATA_W-1:0] instr_mem    [DEPTH];
  logic              gp_we_mem    [DEPTH];
  logic [GP_AW-1:0]  gp_addr_mem  [DEPTH];
  logic [DATA_W-1:0] gp_data_mem  [DEPTH];
  logic              sr_we_mem    [DEPTH];
  logic [SR_AW-1:0]  sr_addr_mem  [DEPTH];
  logic [ADDR_W-1:0] sr_data_mem  [DEPTH];
  logic              ar_we_mem    [DEPTH];
  logic [AR_AW-1:0]  ar_addr_mem  [DEPTH];
  logic [ADDR_W-1:0] ar_data_mem  [DEPTH];

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

  logic              ready;
  logic              push;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Handshake: ready depends on registered occupancy only, never on drain_en
  always_comb begin
    ready = (count_q != FULL_CNT);
    push  = bus.iw_valid & ready;
    pop   = (count_q != '0) & bus.iw_drain_en;
  end

  // Next-state for pointers, occupancy and the retire history registers
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d       = head_q + PTR_W'(1);
      pc_d         = pc_mem[head_q];
      instr_d      = instr_mem[head_q];
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset discards every pending record
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // One write slot per entry: the whole record lands at tail on push
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge iw_clk) begin
      if (push && (tail_q == PTR_W'(gi))) begin
        pc_mem[gi]      <= bus.iw_pc;
        instr_mem[gi]   <= bus.iw_instr;
        gp_we_mem[gi]   <= bus.iw_gp_we;
        gp_addr_mem[gi] <= bus.iw_gp_addr;
        gp_data_mem[gi] <= bus.iw_result;
        sr_we_mem[gi]   <= bus.iw_sr_we;
        sr_addr_mem[gi] <= bus.iw_sr_addr;
        sr_data_mem[gi] <= bus.iw_sr_result;
        ar_we_mem[gi]   <= bus.iw_ar_we;
        ar_addr_mem[gi] <= bus.iw_ar_addr;
        ar_data_mem[gi] <= bus.iw_ar_result;
      end
    end
  end

  // Forwarding: walk occupied entries oldest to youngest so the last match wins
  always_comb begin
    logic [PTR_W-1:0] slot;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_BITS'(i) < count_q) && gp_we_mem[slot] &&
          (gp_addr_mem[slot] == bus.iw_fwd_gp_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = gp_data_mem[slot];
      end
    end
  end

  // Output drive: head entry feeds the write ports, enables gated by pop
  always_comb begin
    bus.ow_ready           = ready;
    bus.ow_gp_write_enable = gp_we_mem[head_q] & pop;
    bus.ow_gp_write_addr   = gp_addr_mem[head_q];
    bus.ow_gp_write_data   = gp_data_mem[head_q];
    bus.ow_sr_write_enable = sr_we_mem[head_q] & pop;
    bus.ow_sr_write_addr   = sr_addr_mem[head_q];
    bus.ow_sr_write_data   = sr_data_mem[head_q];
    bus.ow_ar_write_enable = ar_we_mem[head_q] & pop;
    bus.ow_ar_write_addr   = ar_addr_mem[head_q];
    bus.ow_ar_write_data   = ar_data_mem[head_q];
    bus.ow_retire          = pop;
    bus.ow_pc              = pc_q;
    bus.ow_instr           = instr_q;
    bus.ow_count           = count_q;
    bus.ow_retire_count    = retire_cnt_q;
    bus.ow_fwd_gp_hit      = fwd_hit;
    bus.ow_fwd_gp_data     = fwd_data;
  end
endmodule

// File: tb/tb_stg_wb_q.sv
// Directed bench for the writeback retire queue. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns later, well away from the edge.
// A second instance with a 2-bit retire counter exercises counter wrap.
module tb_stg_wb_q;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 48;
  localparam int GP_AW  = 4;
  localparam int SR_AW  = 2;
  localparam int AR_AW  = 2;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  stg_wb_q_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GP_AW(GP_AW), .SR_AW(SR_AW),
                .AR_AW(AR_AW), .DEPTH(DEPTH), .CNT_W(32)) bus ();
  stg_wb_q_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GP_AW(GP_AW), .SR_AW(SR_AW),
                .AR_AW(AR_AW), .DEPTH(DEPTH), .CNT_W(2)) bw ();

  stg_wb_q #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GP_AW(GP_AW), .SR_AW(SR_AW),
             .AR_AW(AR_AW), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (bus)
  );

  stg_wb_q #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GP_AW(GP_AW), .SR_AW(SR_AW),
             .AR_AW(AR_AW), .DEPTH(DEPTH), .CNT_W(2)) dut_w (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a record onto the main bus (valid is driven separately)
  task automatic rec(input logic [47:0] pc, input logic [23:0] instr,
                     input logic gwe, input logic [3:0] ga, input logic [23:0] res,
                     input logic swe, input logic awe);
    bus.iw_pc        = pc;
    bus.iw_instr     = instr;
    bus.iw_gp_we     = gwe;
    bus.iw_gp_addr   = ga;
    bus.iw_result    = res;
    bus.iw_sr_we     = swe;
    bus.iw_sr_addr   = 2'd1;
    bus.iw_sr_result = {pc[23:0], res};
    bus.iw_ar_we     = awe;
    bus.iw_ar_addr   = 2'd3;
    bus.iw_ar_result = pc + 48'h1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.iw_valid = 1'b0;
    bus.iw_drain_en = 1'b1;
    bus.iw_fwd_gp_addr = '0;
    rec(48'h0, 24'h0, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    bw.iw_valid = 1'b0;      bw.iw_drain_en = 1'b1;  bw.iw_fwd_gp_addr = '0;
    bw.iw_pc = 48'h900;      bw.iw_instr = 24'h9;
    bw.iw_gp_we = 1'b0;      bw.iw_gp_addr = '0;     bw.iw_result = '0;
    bw.iw_sr_we = 1'b0;      bw.iw_sr_addr = '0;     bw.iw_sr_result = '0;
    bw.iw_ar_we = 1'b0;      bw.iw_ar_addr = '0;     bw.iw_ar_result = '0;

    // ---- reset state ----
    tick(); tick(); #1;
    check("rst_ready", bus.ow_ready, 1);
    check("rst_count", bus.ow_count, 0);
    check("rst_rcnt", bus.ow_retire_count, 0);
    check("rst_pc", bus.ow_pc, 0);
    check("rst_instr", bus.ow_instr, 0);
    check("rst_retire", bus.ow_retire, 0);
    check("rst_gp_we", bus.ow_gp_write_enable, 0);
    check("rst_fwd_hit", bus.ow_fwd_gp_hit, 0);
    rst_n = 1'b1;

    // ---- single record, one-cycle latency ----
    rec(48'h100, 24'h111111, 1'b1, 4'd3, 24'h00ABCD, 1'b0, 1'b0);
    bus.iw_valid = 1'b1;
    tick();
    bus.iw_valid = 1'b0; #1;
    check("t1_gp_we", bus.ow_gp_write_enable, 1);
    check("t1_gp_addr", bus.ow_gp_write_addr, 3);
    check("t1_gp_data", bus.ow_gp_write_data, 24'h00ABCD);
    check("t1_sr_we", bus.ow_sr_write_enable, 0);
    check("t1_retire", bus.ow_retire, 1);
    tick(); #1;
    check("t1_pc", bus.ow_pc, 48'h100);
    check("t1_instr", bus.ow_instr, 24'h111111);
    check("t1_rcnt", bus.ow_retire_count, 1);
    check("t1_count", bus.ow_count, 0);
    check("t1_retire_lo", bus.ow_retire, 0);

    // ---- fill to full, refuse fifth, drain in order ----
    bus.iw_drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec(48'h200 + 48'(4 * i), 24'hA000 + 24'(i), (i != 3), 4'(i + 1),
          24'(16 * (i + 1)), (i == 1), (i == 2));
      bus.iw_valid = 1'b1;
      tick();
    end
    bus.iw_valid = 1'b0; #1;
    check("t2_count_full", bus.ow_count, 4);
    check("t2_ready_full", bus.ow_ready, 0);
    rec(48'h300, 24'hBBBBBB, 1'b1, 4'd9, 24'h999999, 1'b0, 1'b0);
    bus.iw_valid = 1'b1;
    tick();
    bus.iw_valid = 1'b0; #1;
    check("t2_count_refuse", bus.ow_count, 4);
    bus.iw_drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_gp_we", bus.ow_gp_write_enable, (i != 3));
      check("t2_sr_we", bus.ow_sr_write_enable, (i == 1));
      check("t2_ar_we", bus.ow_ar_write_enable, (i == 2));
      check("t2_gp_addr", bus.ow_gp_write_addr, 64'(i + 1));
      check("t2_gp_data", bus.ow_gp_write_data, 64'(16 * (i + 1)));
      check("t2_retire", bus.ow_retire, 1);
      tick();
      if (i == 0) check("t2_ready_back", bus.ow_ready, 1);
    end
    #1;
    check("t2_count_empty", bus.ow_count, 0);
    check("t2_pc", bus.ow_pc, 48'h20C);
    check("t2_instr", bus.ow_instr, 24'hA003);
    check("t2_rcnt", bus.ow_retire_count, 5);

    // ---- full with simultaneous push/pop ----
    bus.iw_drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec(48'h400 + 48'(i), 24'(i), 1'b1, 4'd7, 24'(i + 1), 1'b0, 1'b0);
      bus.iw_valid = 1'b1;
      tick();
    end
    rec(48'h500, 24'h5, 1'b1, 4'd7, 24'h55, 1'b0, 1'b0);
    bus.iw_drain_en = 1'b1; #1;
    check("t3_ready_full", bus.ow_ready, 0);
    check("t3_head_data", bus.ow_gp_write_data, 1);
    tick(); #1;
    check("t3_count_3", bus.ow_count, 3);
    check("t3_ready_freed", bus.ow_ready, 1);
    tick();
    bus.iw_valid = 1'b0; #1;
    check("t3_count_pushpop", bus.ow_count, 3);
    check("t3_head_a", bus.ow_gp_write_data, 3);
    tick(); #1;
    check("t3_head_b", bus.ow_gp_write_data, 4);
    tick(); #1;
    check("t3_head_c", bus.ow_gp_write_data, 24'h55);
    tick(); #1;
    check("t3_count_empty", bus.ow_count, 0);
    check("t3_pc", bus.ow_pc, 48'h500);
    check("t3_rcnt", bus.ow_retire_count, 10);

    // ---- forwarding: youngest match, we=0 ignored, push not visible ----
    bus.iw_drain_en = 1'b0;
    bus.iw_fwd_gp_addr = 4'd5;
    rec(48'h600, 24'h6, 1'b1, 4'd5, 24'h000011, 1'b0, 1'b0); bus.iw_valid = 1'b1; tick();
    rec(48'h604, 24'h6, 1'b1, 4'd5, 24'h000022, 1'b0, 1'b0); tick();
    rec(48'h608, 24'h6, 1'b0, 4'd5, 24'h000099, 1'b0, 1'b0); tick();
    rec(48'h60C, 24'h6, 1'b1, 4'd5, 24'h000077, 1'b0, 1'b0); #1;
    check("t4_hit_r5", bus.ow_fwd_gp_hit, 1);
    check("t4_data_r5", bus.ow_fwd_gp_data, 24'h000022);
    tick();
    bus.iw_valid = 1'b0; #1;
    check("t4_data_young", bus.ow_fwd_gp_data, 24'h000077);
    bus.iw_fwd_gp_addr = 4'd6; #1;
    check("t4_hit_r6", bus.ow_fwd_gp_hit, 0);
    check("t4_data_r6", bus.ow_fwd_gp_data, 0);
    bus.iw_fwd_gp_addr = 4'd5;
    bus.iw_drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_hit_pop", bus.ow_fwd_gp_hit, 1);
      check("t4_data_pop", bus.ow_fwd_gp_data, 24'h000077);
      tick();
    end
    #1;
    check("t4_hit_empty", bus.ow_fwd_gp_hit, 0);
    check("t4_data_empty", bus.ow_fwd_gp_data, 0);
    check("t4_rcnt", bus.ow_retire_count, 14);

    // ---- mixed SR/AR record ----
    bus.iw_drain_en = 1'b0;
    rec(48'h700, 24'h777777, 1'b0, 4'd5, 24'h33, 1'b1, 1'b1);
    bus.iw_sr_addr = 2'd2;  bus.iw_sr_result = 48'hDEADBEEF0001;
    bus.iw_ar_addr = 2'd1;  bus.iw_ar_result = 48'h000000000040;
    bus.iw_valid = 1'b1;
    tick();
    bus.iw_valid = 1'b0;
    bus.iw_drain_en = 1'b1; #1;
    check("t5_gp_we", bus.ow_gp_write_enable, 0);
    check("t5_sr_we", bus.ow_sr_write_enable, 1);
    check("t5_sr_addr", bus.ow_sr_write_addr, 2);
    check("t5_sr_data", bus.ow_sr_write_data, 48'hDEADBEEF0001);
    check("t5_ar_we", bus.ow_ar_write_enable, 1);
    check("t5_ar_addr", bus.ow_ar_write_addr, 1);
    check("t5_ar_data", bus.ow_ar_write_data, 48'h40);
    tick(); #1;
    check("t5_rcnt", bus.ow_retire_count, 15);
    check("t5_instr", bus.ow_instr, 24'h777777);

    // ---- retire counter wrap on the 2-bit-counter instance (all-we-low records) ----
    bw.iw_valid = 1'b1;
    tick(); tick(); tick(); tick();
    bw.iw_valid = 1'b0; #1;
    check("w_rcnt_max", bw.ow_retire_count, 3);
    check("w_retire", bw.ow_retire, 1);
    check("w_gp_we", bw.ow_gp_write_enable, 0);
    tick(); #1;
    check("w_rcnt_wrap", bw.ow_retire_count, 0);
    check("w_count", bw.ow_count, 0);

    // ---- reset with pending entries ----
    bus.iw_drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rec(48'h800 + 48'(i), 24'h8, 1'b1, 4'(i), 24'hF0 + 24'(i), 1'b1, 1'b1);
      bus.iw_valid = 1'b1;
      tick();
    end
    bus.iw_valid = 1'b0; #1;
    check("t6_count_pend", bus.ow_count, 3);
    rst_n = 1'b0;
    bus.iw_drain_en = 1'b1; #1;
    check("t6_count", bus.ow_count, 0);
    check("t6_gp_we", bus.ow_gp_write_enable, 0);
    check("t6_sr_we", bus.ow_sr_write_enable, 0);
    check("t6_ar_we", bus.ow_ar_write_enable, 0);
    check("t6_retire", bus.ow_retire, 0);
    check("t6_rcnt", bus.ow_retire_count, 0);
    check("t6_pc", bus.ow_pc, 0);
    check("t6_ready", bus.ow_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_no_stale_we", bus.ow_gp_write_enable, 0);
      check("t6_no_stale_ret", bus.ow_retire, 0);
      tick();
    end
    #1;
    check("t6_count_after", bus.ow_count, 0);
    check("t6_rcnt_after", bus.ow_retire_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
